fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Shadows destination/source register info through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the 2-bit selects of the two EX-stage 3-input operand muxes (ALU A, ALU B/store data).
- Detects load-use hazards and stalls IF/ID while injecting a bubble into ID/EX.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  external freeze (memory wait); all internal state holds.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_AW  ID source register 1.
- id_rt  input  REG_AW  ID source register 2.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_rd  input  REG_AW  ID destination register (already rt/rd/31 muxed).
- id_wr  input  1  instruction writes the register file.
- id_load  input  1  instruction is a load.
- fwd_a_sel  output  2  ALU-A mux select.
- fwd_b_sel  output  2  ALU-B/store-data mux select.
- stall_ifid  output  1  hold PC and IF/ID.
- bubble_idex  output  1  load a NOP into ID/EX.
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Select encoding: 0 = register file, 1 = MEM/WB result, 2 = EX/MEM result.
- The code 3 is never driven: the downstream mux does not update on 3.
- State registers:
  - ID/EX: ex_rs, ex_rt, ex_use_rs, ex_use_rt, ex_rd, ex_wr, ex_load.
  - EX/MEM: mem_rd, mem_wr, mem_load.
  - MEM/WB: wb_rd, wb_wr.
- Reset: all state and stall_cnt clear to 0. Outputs are then fwd_*=0, stall_ifid=0, bubble_idex=0.
- Load-use hazard (combinational from ID inputs and ID/EX state):
  - hz = id_valid & ex_load & ex_wr & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - stall_ifid = bubble_idex = hz & ~hold.
- Advance on clk when hold=0:
  - MEM/WB <- EX/MEM.
  - EX/MEM <- ID/EX.
  - ID/EX <- ID inputs, or a bubble (all write/use flags 0) if hz or ~id_valid.
- hold=1: no register changes, and stall_cnt does not count.
- fwd_a_sel:
  - 2 if ex_use_rs & mem_wr & mem_rd!=0 & mem_rd==ex_rs & ~mem_load.
  - Else 1 if ex_use_rs & wb_wr & wb_rd!=0 & wb_rd==ex_rs.
  - Else 0.
  - EX/MEM has priority: it holds the newest value.
- fwd_b_sel: same rules using ex_rt / ex_use_rt.
- Forwarding selects depend on state registers only (no combinational path from id_* inputs). Latency: selects are valid for the entire EX cycle of the consumer.
- mem_load & match cannot occur: the stall guarantees at least one bubble. If it did occur, the select falls through to the MEM/WB check (never selects 2). This is an assertion target.
- Register 0 is never forwarded and never causes a stall.
- The register file is write-before-read, so WB->ID forwarding is not this block's job.
- stall_cnt increments on each clocked cycle with hz & ~hold, and saturates at all-ones.
- Asynchronous reset mid-operation drops all in-flight hazard state immediately. After release, the first instruction sees fwd_*=0.
- Back-to-back loads: the second load depending on the first stalls once; the bubble carries ex_load=0, so there is no double stall.

Decomposition:
- Package fwd_pkg holds SEL_RF=2'd0, SEL_WB=2'd1, SEL_MEM=2'd2, and a stage-info struct (rd, wr, load).
- One sub-module fwd_sel_logic (priority compare for one operand), instantiated twice for A and B.

Test Plan:
- Reset, no writes -> fwd_a_sel=fwd_b_sel=0, stall_cnt=0.
- add $3,$1,$2 then sub $4,$3,$5 -> in the sub's EX cycle, fwd_a_sel=2, fwd_b_sel=0.
- add $3,.., nop, or $6,$7,$3 -> or's EX has fwd_b_sel=1.
- lw $8,0($9) then add $10,$8,$8:
  - stall_ifid=bubble_idex=1 for exactly 1 cycle.
  - Next add EX has fwd_a_sel=fwd_b_sel=1.
  - stall_cnt=1.
- Write to $0 followed by a reader of $0 -> selects 0, no stall.
- Assert hold=1 during a pending load-use -> stall_ifid=0 and state frozen while held. On release, the stall occurs once, stall_cnt+1. Pulsing rst_n low mid-sequence clears all state and outputs asynchronously.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared select codes and per-stage destination info for the forwarding/hazard controller.
package fwd_pkg;

  localparam int PKG_REG_AW = 5;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  // rd width is fixed at PKG_REG_AW; the controller's REG_AW parameter must match it.
  typedef struct packed {
    logic [PKG_REG_AW-1:0] rd;
    logic                  wr;
    logic                  load;
  } stage_info_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Priority forwarding select for one EX-stage operand: EX/MEM beats MEM/WB beats register file.
module fwd_sel_logic
  import fwd_pkg::*;
#(
  parameter int REG_AW = PKG_REG_AW
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  stage_info_t       mem_info,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr,
  output logic [1:0]        sel
);

  // A load in EX/MEM has no data yet, so it falls through to the MEM/WB check.
  always_comb begin
    sel = SEL_RF;
    if (use_src && (src != '0)) begin
      if (mem_info.wr && !mem_info.load && (mem_info.rd == src))
        sel = SEL_MEM;
      else if (wb_wr && (wb_rd == src))
        sel = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage core: shadows ID/EX, EX/MEM and
// MEM/WB destination info, drives the EX operand mux selects and stalls on load-use.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = PKG_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_use_rs;
  logic              ex_use_rt;
  stage_info_t       ex_info;
  stage_info_t       mem_info;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_wr;
  logic              hz;
  logic              stall_now;

  assign hz = id_valid && ex_info.load && ex_info.wr && (ex_info.rd != '0) &&
              ((id_use_rs && (id_rs == ex_info.rd)) || (id_use_rt && (id_rt == ex_info.rd)));

  assign stall_now   = hz && !hold;
  assign stall_ifid  = stall_now;
  assign bubble_idex = stall_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
      ex_info   <= '0;
      mem_info  <= '0;
      wb_rd     <= '0;
      wb_wr     <= 1'b0;
    end else if (!hold) begin
      wb_rd    <= mem_info.rd;
      wb_wr    <= mem_info.wr;
      mem_info <= ex_info;
      if (hz || !id_valid) begin
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_use_rs <= 1'b0;
        ex_use_rt <= 1'b0;
        ex_info   <= '0;
      end else begin
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_use_rs    <= id_use_rs;
        ex_use_rt    <= id_use_rt;
        ex_info.rd   <= id_rd;
        ex_info.wr   <= id_wr;
        ex_info.load <= id_load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_now && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_a (
    .use_src  (ex_use_rs),
    .src      (ex_rs),
    .mem_info (mem_info),
    .wb_rd    (wb_rd),
    .wb_wr    (wb_wr),
    .sel      (fwd_a_sel)
  );

  fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_b (
    .use_src  (ex_use_rt),
    .src      (ex_rt),
    .mem_info (mem_info),
    .wb_rd    (wb_rd),
    .wb_wr    (wb_wr),
    .sel      (fwd_b_sel)
  );

  // The load-use stall must always leave a bubble between a load and its consumer.
  a_no_load_in_mem_rs: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_use_rs && mem_info.wr && mem_info.load && (mem_info.rd != '0) && (mem_info.rd == ex_rs)));
  a_no_load_in_mem_rt: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_use_rt && mem_info.wr && mem_info.load && (mem_info.rd != '0) && (mem_info.rd == ex_rt)));
  a_sel_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (fwd_a_sel != 2'd3) && (fwd_b_sel != 2'd3));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed MIPS sequences plus random traffic vs a pipeline model.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr = 1'b0, id_load = 1'b0;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_ifid, bubble_idex;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit [4:0] rs, rt, rd;
    bit       urs, urt, wr, ld;
  } instr_t;

  typedef struct {
    bit [1:0]  a, b;
    bit        st;
    bit [15:0] cnt;
  } exp_t;

  exp_t   sb[$];
  instr_t nop_i = '{rs: 0, rt: 0, rd: 0, urs: 0, urt: 0, wr: 0, ld: 0};
  instr_t m_ex, m_mem, m_wb;
  int     m_cnt = 0;
  int     vectors = 0;
  int     miscompares = 0;

  function automatic instr_t mk(int rs, int rt, bit urs, bit urt, int rd, bit wr, bit ld);
    instr_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
    i.rd = 5'(rd); i.wr = wr; i.ld = ld;
    return i;
  endfunction

  // Newest older instruction with a ready result for register r; loads still in MEM have no data.
  function automatic bit [1:0] source_of(bit [4:0] r, bit used);
    if (!used || r == 0) return 2'd0;
    if (m_mem.wr && m_mem.rd == r && !m_mem.ld) return 2'd2;
    if (m_wb.wr && m_wb.rd == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit load_use(instr_t id, bit v);
    return v && m_ex.ld && m_ex.wr && m_ex.rd != 0 &&
           ((id.urs && id.rs == m_ex.rd) || (id.urt && id.rt == m_ex.rd));
  endfunction

  task automatic model_reset();
    m_ex = nop_i; m_mem = nop_i; m_wb = nop_i; m_cnt = 0;
  endtask

  task automatic step(input instr_t id, input bit v, input bit h, output bit stalled);
    exp_t e;
    bit   hz;
    @(negedge clk);
    id_valid = v; hold = h;
    id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
    id_use_rs = id.urs; id_use_rt = id.urt; id_wr = id.wr; id_load = id.ld;
    #1;
    hz = load_use(id, v);
    e.a = source_of(m_ex.rs, m_ex.urs);
    e.b = source_of(m_ex.rt, m_ex.urt);
    e.st = hz && !h;
    e.cnt = 16'(m_cnt);
    sb.push_back(e);
    stalled = e.st;
    @(posedge clk);
    if (!h) begin
      if (hz && m_cnt < 65535) m_cnt++;
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = (hz || !v) ? nop_i : id;
    end
  endtask

  // Present one instruction until it is accepted (repeats while stalled).
  task automatic issue(input instr_t id);
    bit st;
    for (int k = 0; k < 8; k++) begin
      step(id, 1'b1, 1'b0, st);
      if (!st) return;
    end
    $display("FAIL issue-bound: instruction rd=%0d still stalled after 8 cycles", id.rd);
    vectors++; miscompares++;
  endtask

  task automatic bubble(input int n);
    bit st;
    for (int k = 0; k < n; k++) step(nop_i, 1'b0, 1'b0, st);
  endtask

  task automatic direct_check(input string name, input logic [15:0] cnt_exp);
    vectors++;
    if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || stall_ifid !== 1'b0 ||
        bubble_idex !== 1'b0 || stall_cnt !== cnt_exp) begin
      miscompares++;
      $display("FAIL %s: got a=%0d b=%0d st=%0d bub=%0d cnt=%0d, expected a=0 b=0 st=0 bub=0 cnt=%0d",
               name, fwd_a_sel, fwd_b_sel, stall_ifid, bubble_idex, stall_cnt, cnt_exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (fwd_a_sel !== e.a || fwd_b_sel !== e.b || stall_ifid !== e.st ||
            bubble_idex !== e.st || stall_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL cycle-vec %0d @%0t: got a=%0d b=%0d st=%0d bub=%0d cnt=%0d, expected a=%0d b=%0d st=%0d bub=%0d cnt=%0d",
                   vectors, $time, fwd_a_sel, fwd_b_sel, stall_ifid, bubble_idex, stall_cnt,
                   e.a, e.b, e.st, e.st, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    bit st;
    model_reset();
    #3;
    direct_check("reset-state", 16'd0);
    #9 rst_n = 1'b1;
    bubble(2);

    // add $3,$1,$2 ; sub $4,$3,$5  -> sub EX: a=2
    issue(mk(1, 2, 1, 1, 3, 1, 0));
    issue(mk(3, 5, 1, 1, 4, 1, 0));
    bubble(3);

    // add $3 ; nop ; or $6,$7,$3  -> or EX: b=1
    issue(mk(1, 2, 1, 1, 3, 1, 0));
    bubble(1);
    issue(mk(7, 3, 1, 1, 6, 1, 0));
    bubble(3);

    // lw $8,0($9) ; add $10,$8,$8  -> one stall, then a=b=1
    issue(mk(9, 0, 1, 0, 8, 1, 1));
    issue(mk(8, 8, 1, 1, 10, 1, 0));
    bubble(3);
    @(negedge clk); #2;
    direct_check("lw-use-count", 16'd1);

    // load to $0 then reader of $0: no stall, no forwarding
    issue(mk(1, 2, 1, 1, 0, 1, 1));
    issue(mk(0, 0, 1, 1, 5, 1, 0));
    bubble(3);

    // hold during a pending load-use, then release
    issue(mk(9, 0, 1, 0, 8, 1, 1));
    for (int k = 0; k < 3; k++) step(mk(2, 8, 1, 1, 11, 1, 0), 1'b1, 1'b1, st);
    issue(mk(2, 8, 1, 1, 11, 1, 0));
    bubble(3);

    // back-to-back dependent loads: single stall
    issue(mk(9, 0, 1, 0, 8, 1, 1));
    issue(mk(8, 0, 1, 0, 9, 1, 1));
    issue(mk(9, 8, 1, 1, 12, 1, 0));
    bubble(3);

    // async reset with forwarding and a load in flight
    issue(mk(1, 2, 1, 1, 3, 1, 0));
    step(mk(3, 0, 1, 0, 8, 1, 1), 1'b1, 1'b0, st);
    #2 rst_n = 1'b0;
    model_reset();
    #1 direct_check("async-reset", 16'd0);
    #1 rst_n = 1'b1;
    issue(mk(8, 3, 1, 1, 13, 1, 0));
    bubble(3);

    for (int n = 0; n < 1500; n++) begin
      step(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), ($urandom_range(0, 7) != 0), 1'($urandom)),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), st);
    end
    hold = 1'b0;
    bubble(2);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
